prog_loader: RTL and testbench

// - Upstream feeder for the program RAM external-write port. Receives a byte stream over a valid/ready

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-stream program loader: assembles big-endian 16-bit words and writes them to consecutive program RAM addresses.
// Optional trailing XOR checksum byte is enabled by defining PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int               ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter logic [3:0]       END_OP    = 4'b1100
) (
    input  logic              clk,
    input  logic              sys_rst,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              prog_wd,
    output logic              prog_cs_d,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [15:0]       prog_din,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

`ifdef PROG_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_RX_HI, S_RX_LO, S_WRITE, S_CHK, S_DONE, S_ERR} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RX_HI, S_RX_LO, S_WRITE, S_DONE, S_ERR} state_t;
`endif

    state_t     state, state_n;
    logic [7:0] hi_byte;
    logic       xfer;
    logic       start;
    logic       end_word;

    assign xfer     = in_valid && in_ready;
    assign start    = load_start && (state == S_IDLE || state == S_DONE || state == S_ERR);
    assign end_word = (prog_din[15:12] == END_OP);

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: if (load_start) state_n = S_RX_HI;
            S_RX_HI:               if (xfer) state_n = S_RX_LO;
            S_RX_LO:               if (xfer) state_n = S_WRITE;
            S_WRITE: begin
                if (end_word)
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_n = S_CHK;
`else
                    state_n = S_DONE;
`endif
                else if (prog_addr == '1)
                    state_n = S_ERR;   // no wrap-around into already written words
                else
                    state_n = S_RX_HI;
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CHK:                 if (xfer) state_n = (in_data == csum) ? S_DONE : S_ERR;
`endif
            default:               state_n = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            prog_wd    <= 1'b0;
            prog_cs_d  <= 1'b1;
            prog_addr  <= BASE_ADDR;
            prog_din   <= '0;
            hi_byte    <= '0;
            load_busy  <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
            word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state     <= state_n;
`ifdef PROG_LOADER_CHECKSUM_EN
            in_ready  <= (state_n == S_RX_HI) || (state_n == S_RX_LO) || (state_n == S_CHK);
            load_busy <= (state_n == S_RX_HI) || (state_n == S_RX_LO) ||
                         (state_n == S_WRITE) || (state_n == S_CHK);
`else
            in_ready  <= (state_n == S_RX_HI) || (state_n == S_RX_LO);
            load_busy <= (state_n == S_RX_HI) || (state_n == S_RX_LO) || (state_n == S_WRITE);
`endif
            prog_wd   <= (state_n == S_WRITE);
            prog_cs_d <= (state_n != S_WRITE);
            load_done <= (state_n == S_DONE);
            load_err  <= (state_n == S_ERR);

            if (start) begin
                prog_addr  <= BASE_ADDR;
                word_count <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum       <= '0;
`endif
            end

            if (state == S_RX_HI && xfer) begin
                hi_byte <= in_data;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum    <= csum ^ in_data;
`endif
            end

            if (state == S_RX_LO && xfer) begin
                prog_din <= {hi_byte, in_data};
`ifdef PROG_LOADER_CHECKSUM_EN
                csum     <= csum ^ in_data;
`endif
            end

            if (state == S_WRITE) begin
                word_count <= word_count + (ADDR_W+1)'(1);
                if (state_n == S_RX_HI) prog_addr <= prog_addr + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, hand-written corner sequences and randomized loads vs a word-level model.
module tb_prog_loader;
    localparam logic [7:0] BASE = 8'h00;
    localparam logic [3:0] ENDOP = 4'b1100;

    logic        clk = 1'b0, sys_rst = 1'b1, load_start = 1'b0, in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, prog_wd, prog_cs_d, load_busy, load_done, load_err;
    logic [7:0]  prog_addr;
    logic [15:0] prog_din;
    logic [8:0]  word_count;

    prog_loader #(.ADDR_W(8), .BASE_ADDR(BASE), .END_OP(ENDOP)) dut (
        .clk(clk), .sys_rst(sys_rst), .load_start(load_start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .prog_wd(prog_wd), .prog_cs_d(prog_cs_d),
        .prog_addr(prog_addr), .prog_din(prog_din), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] a; logic [15:0] d; } wr_t;
    wr_t wr_log[$];
    int  wd_cycles = 0;
    int  n_chk = 0, n_fail = 0;

    always @(posedge clk) begin
        if (prog_wd && !prog_cs_d) wr_log.push_back({prog_addr, prog_din});
        if (prog_wd) wd_cycles++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1; step(); load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int t = 0;
        int g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) step();
        in_valid = 1'b1; in_data = b;
        while (!in_ready && t < 50) begin step(); t++; end
        if (t >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL in_ready_timeout: got 0, expected 1");
        end else step();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (load_busy && t < 50) begin step(); t++; end
        if (t >= 50) begin
            n_chk++; n_fail++;
            $display("FAIL busy_timeout: got 1, expected 0");
        end
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] q[$]);
        logic [7:0] x = '0;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    // Append the trailing checksum byte when the design expects one.
    task automatic finish_stream(inout logic [7:0] q[$]);
`ifdef PROG_LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = xsum(q);
        q.push_back(c);
`endif
    endtask

    task automatic run_load(input logic [7:0] q[$], input int maxgap);
        wr_log.delete();
        pulse_start();
        foreach (q[i]) send_byte(q[i], maxgap);
        step();
        wait_idle();
    endtask

    // Word-level reference: pair bytes, write sequentially, stop on END_OP or address overflow.
    task automatic model(input logic [7:0] q[$], output wr_t exp[$], output logic done, output logic err);
        int addr = int'(BASE);
        logic [15:0] w;
        exp = {}; done = 1'b0; err = 1'b0;
        for (int i = 0; i + 1 < q.size(); i += 2) begin
            w = {q[i], q[i+1]};
            exp.push_back({addr[7:0], w});
            if (w[15:12] == ENDOP) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                logic [7:0] pre[$];
                pre = q[0:i+1];
                done = (i + 2 < q.size()) && (q[i+2] == xsum(pre));
                err = !done;
`else
                done = 1'b1;
`endif
                break;
            end
            if (addr == 255) begin err = 1'b1; break; end
            addr++;
        end
    endtask

    task automatic check_model(input string tag, input logic [7:0] q[$]);
        wr_t exp[$];
        logic d, e;
        model(q, exp, d, e);
        chk({tag, "_done"}, load_done, d);
        chk({tag, "_err"}, load_err, e);
        chk({tag, "_wc"}, word_count, exp.size());
        chk({tag, "_nwr"}, wr_log.size(), exp.size());
        if (wr_log.size() == exp.size())
            foreach (exp[i]) chk({tag, "_wr"}, wr_log[i], exp[i]);
        chk({tag, "_din"}, prog_din, exp[exp.size()-1].d);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_prog_wd"}, prog_wd, 0);
        chk({tag, "_cs_d"}, prog_cs_d, 1);
        chk({tag, "_addr"}, prog_addr, BASE);
        chk({tag, "_din"}, prog_din, 0);
        chk({tag, "_busy"}, load_busy, 0);
        chk({tag, "_done"}, load_done, 0);
        chk({tag, "_err"}, load_err, 0);
        chk({tag, "_wc"}, word_count, 0);
    endtask

    typedef struct {
        logic [47:0] bytes;   // MSB-first stream
        int          n;
        logic [15:0] din;
        int          wc;
        logic [7:0]  addr;
    } vec_t;

    initial begin
        vec_t        vt[5];
        logic [7:0]  q[$];
        wr_t         ref_log[$];
        int          wd0, ref_wd;
        logic [15:0] w;

        vt[0] = '{48'h1234_5678_C000, 6, 16'hC000, 3, 8'h02};
        vt[1] = '{48'h0000_0000_C000, 2, 16'hC000, 1, 8'h00};
        vt[2] = '{48'h0000_1234_CFFF, 4, 16'hCFFF, 2, 8'h01};
        vt[3] = '{48'h0000_ABCD_C123, 4, 16'hC123, 2, 8'h01};
        vt[4] = '{48'h0000_0C00_C001, 4, 16'hC001, 2, 8'h01};

        repeat (3) step();
        check_reset_vals("reset");
        sys_rst = 1'b0;
        step();

        foreach (vt[v]) begin
            q = {};
            for (int i = vt[v].n - 1; i >= 0; i--) q.push_back(vt[v].bytes[8*i +: 8]);
            finish_stream(q);
            run_load(q, 0);
            chk($sformatf("vec%0d_done", v), load_done, 1);
            chk($sformatf("vec%0d_err", v), load_err, 0);
            chk($sformatf("vec%0d_wc", v), word_count, vt[v].wc);
            chk($sformatf("vec%0d_din", v), prog_din, vt[v].din);
            chk($sformatf("vec%0d_addr", v), prog_addr, vt[v].addr);
            chk($sformatf("vec%0d_nwr", v), wr_log.size(), vt[v].wc);
            if (wr_log.size() > 0) chk($sformatf("vec%0d_first", v), wr_log[0].a, BASE);
        end

        // Latency of the end word: strobe right after the low-byte edge, done one edge later.
        wr_log.delete();
        pulse_start();
        send_byte(8'hC0, 0);
        in_valid = 1'b1; in_data = 8'h00;
        step();
        in_valid = 1'b0;
        chk("lat_wd", prog_wd, 1);
        chk("lat_cs", prog_cs_d, 0);
        chk("lat_ready", in_ready, 0);
        chk("lat_done_early", load_done, 0);
        chk("lat_din", prog_din, 16'hC000);
        step();
        chk("lat_wd_off", prog_wd, 0);
        chk("lat_wc", word_count, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
        chk("lat_chk_ready", in_ready, 1);
        send_byte(8'hC0, 0);
        step();
`endif
        chk("lat_done", load_done, 1);
        chk("lat_busy", load_busy, 0);

        // load_start mid-load is ignored.
        wr_log.delete();
        pulse_start();
        send_byte(8'h12, 0); send_byte(8'h34, 0);
        pulse_start();
        q = {8'h12, 8'h34, 8'h56, 8'h78, 8'hC0, 8'h00};
        send_byte(8'h56, 0); send_byte(8'h78, 0); send_byte(8'hC0, 0); send_byte(8'h00, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(xsum(q), 0);
`endif
        step(); wait_idle();
        finish_stream(q);
        check_model("busy_start", q);

        // Gapped stream matches the gap-free one, two strobes in total.
        q = {8'h12, 8'h34, 8'hC0, 8'h00};
        finish_stream(q);
        wd0 = wd_cycles;
        run_load(q, 0);
        ref_log = wr_log;
        ref_wd = wd_cycles - wd0;
        wd0 = wd_cycles;
        run_load(q, 5);
        chk("gap_nwr", wr_log.size(), ref_log.size());
        if (wr_log.size() == ref_log.size()) foreach (ref_log[i]) chk("gap_wr", wr_log[i], ref_log[i]);
        chk("gap_wd_cycles", wd_cycles - wd0, 2);
        chk("nogap_wd_cycles", ref_wd, 2);

        // Overflow: 256 non-end words fill the address space then error out.
        q = {};
        repeat (256) begin q.push_back(8'h11); q.push_back(8'h11); end
        run_load(q, 0);
        chk("ovf_err", load_err, 1);
        chk("ovf_done", load_done, 0);
        chk("ovf_wc", word_count, 256);
        chk("ovf_nwr", wr_log.size(), 256);
        chk("ovf_last_addr", wr_log[wr_log.size()-1].a, 8'hFF);
        chk("ovf_addr_hold", prog_addr, 8'hFF);
        chk("ovf_ready", in_ready, 0);

        // Reset mid-load, then restart at the base address.
        pulse_start();
        send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
        sys_rst = 1'b1;
        step();
        check_reset_vals("midrst");
        sys_rst = 1'b0;
        step();
        q = {8'hC0, 8'h00};
        finish_stream(q);
        run_load(q, 0);
        check_model("after_rst", q);
        chk("after_rst_addr", wr_log[0].a, BASE);

`ifdef PROG_LOADER_CHECKSUM_EN
        q = {8'h12, 8'h34, 8'hC0, 8'h00, 8'hE6};
        run_load(q, 0);
        chk("csum_ok_done", load_done, 1);
        chk("csum_ok_err", load_err, 0);
        q = {8'h12, 8'h34, 8'hC0, 8'h00, 8'hE7};
        run_load(q, 0);
        chk("csum_bad_done", load_done, 0);
        chk("csum_bad_err", load_err, 1);
`endif

        // Randomized loads against the word-level model.
        for (int r = 0; r < 20; r++) begin
            int nw = int'($urandom_range(6, 1));
            q = {};
            for (int k = 0; k < nw; k++) begin
                w = 16'($urandom);
                if (k == nw - 1) w[15:12] = ENDOP;
                else if (w[15:12] == ENDOP) w[15:12] = 4'h3;
                q.push_back(w[15:8]); q.push_back(w[7:0]);
            end
            finish_stream(q);
`ifdef PROG_LOADER_CHECKSUM_EN
            if ($urandom_range(3, 0) == 0) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
`endif
            run_load(q, 3);
            check_model($sformatf("rnd%0d", r), q);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
